// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e  : E-stage MDU operation encodings (6 and 7 are reserved no-ops)
//   - state_e  : controller FSM states
//   - CNT_W    : width of the busy-window latency counter
//   - is_arith : true for the ops that open a busy window (MULT..DIVU)
package mdu_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E/D-stage view of the multiply/divide unit.
//   start/op/src_a/src_b : operation issue from E
//   rd_sel               : MFLO(0)/MFHI(1) select for rd_data
//   md_use_D             : D-stage instruction touches HI/LO
//   busy/stall           : in-flight flag and hazard stall request
//   hi/lo/rd_data        : committed HI/LO and the selected read value
// master = pipeline side, slave = mdu_ctrl.
interface mdu_ctrl_if;

  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        rd_sel;
  logic        md_use_D;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output start, op, src_a, src_b, rd_sel, md_use_D,
    input  busy, stall, hi, lo, rd_data
  );

  modport slave (
    input  start, op, src_a, src_b, rd_sel, md_use_D,
    output busy, stall, hi, lo, rd_data
  );

endinterface

// File: rtl/mdu_ctrl_arith.sv
// mdu_arith: combinational datapath for the MDU.
//   op          in  3   operation (only MULT/MULTU/DIV/DIVU produce a result)
//   src_a/src_b in  32  operands (dividend/divisor for divides)
//   result      out 64  {hi,lo}: product, or {remainder,quotient}
//   div_by_zero out 1   divide op with src_b==0; result must not be committed
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] sa64, sb64;
  logic signed [31:0] sa, sb, quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;
  logic               b_zero, sdiv_ovf;

  assign sa64     = {{32{src_a[31]}}, src_a};
  assign sb64     = {{32{src_b[31]}}, src_b};
  assign sa       = src_a;
  assign sb       = src_b;
  assign b_zero   = (src_b == 32'd0);
  // The one signed quotient that does not fit in 32 bits; pinned explicitly
  // rather than relying on how the divider wraps.
  assign sdiv_ovf = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

  // Signed '/' truncates toward zero and '%' takes the dividend's sign,
  // which is exactly the DIV contract.
  assign quo_s = sa / sb;
  assign rem_s = sa % sb;
  assign quo_u = src_a / src_b;
  assign rem_u = src_a % src_b;

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    result      = '0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  result = sa64 * sb64;
      MD_MULTU: result = {32'd0, src_a} * {32'd0, src_b};
      MD_DIV: begin
        div_by_zero = b_zero;
        if (sdiv_ovf)     result = {32'd0, 32'h8000_0000};
        else if (!b_zero) result = {rem_s, quo_s};
      end
      MD_DIVU: begin
        div_by_zero = b_zero;
        if (!b_zero) result = {rem_u, quo_u};
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller (XALU source for E).
//   clk    in  pipeline clock
//   reset  in  synchronous active-low reset
//   bus    slave modport of mdu_ctrl_if (issue, read mux, busy/stall, HI/LO)
// The result is computed in the issue cycle and held in pending registers;
// HI/LO are only written when the latency counter expires, so reads never
// see a result before its modelled latency.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  state_e             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [63:0]        pend_res;
  logic               pend_dbz;
  logic [31:0]        hi_q, lo_q;

  logic [63:0]        arith_res;
  logic               arith_dbz;
  logic               launch, commit, is_div;

  mdu_arith u_arith (
    .op          (bus.op),
    .src_a       (bus.src_a),
    .src_b       (bus.src_b),
    .result      (arith_res),
    .div_by_zero (arith_dbz)
  );

  // Issue is only honoured while idle; a start during the busy window is
  // dropped (the stall keeps it from happening in the pipeline anyway).
  assign launch = bus.start && (state == ST_IDLE) && is_arith(bus.op);
  assign commit = (state == ST_RUN) && (cnt == CNT_W'(1));
  assign is_div = (bus.op == MD_DIV) || (bus.op == MD_DIVU);

  // State register.
  // NOTE: reset is sampled inside the clocked block, so it is synchronous;
  // a reset mid-operation simply drops state and pending result.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (launch) state_nx = ST_RUN;
      ST_RUN:  if (commit) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Counter, pending result and HI/LO.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      pend_res <= '0;
      pend_dbz <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (launch) begin
        cnt      <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        pend_res <= arith_res;
        pend_dbz <= arith_dbz;
      end else if (state == ST_RUN) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (commit) begin
        if (!pend_dbz) {hi_q, lo_q} <= pend_res;
      end else if (bus.start && (state == ST_IDLE)) begin
        if (bus.op == MD_MTHI) hi_q <= bus.src_a;
        if (bus.op == MD_MTLO) lo_q <= bus.src_a;
      end
    end
  end

  // Outputs. The stall term includes the issue cycle itself so the D
  // instruction is held with no cycle of lag.
  always_comb begin
    bus.busy    = (state == ST_RUN);
    bus.stall   = bus.md_use_D &
                  ((state == ST_RUN) | (bus.start & is_arith(bus.op)));
    bus.hi      = hi_q;
    bus.lo      = lo_q;
    bus.rd_data = bus.rd_sel ? hi_q : lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: self-checking bench for mdu_ctrl (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
  endtask

  // Issue one arithmetic op, count busy cycles, track stall every cycle,
  // then pop the scoreboard entry and compare the committed HI/LO.
  task automatic run_vec(input vec_t v, input string name);
    exp_t e;
    int   n;
    int   stall_bad;
    @(negedge clk);
    bus.md_use_D = v.md_use;
    issue(v.op, v.a, v.b);
    sb_q.push_back('{hi: v.exp_hi, lo: v.exp_lo, cycles: v.cycles});
    #1;
    stall_bad = (bus.stall !== v.md_use) ? 1 : 0;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      if (bus.stall !== v.md_use) stall_bad++;
      @(negedge clk);
      #1;
    end
    if (bus.stall !== 1'b0) stall_bad++;
    e = sb_q.pop_front();
    check({name, " busy_cycles"}, 64'(n), 64'(e.cycles));
    check({name, " stall_errs"}, 64'(stall_bad), 64'd0);
    check({name, " hi"}, 64'(bus.hi), 64'(e.hi));
    check({name, " lo"}, 64'(bus.lo), 64'(e.lo));
    bus.rd_sel = 1'b1;
    #1;
    check({name, " rd_data_hi"}, 64'(bus.rd_data), 64'(e.hi));
    bus.rd_sel = 1'b0;
    bus.md_use_D = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;

    vecs[0] = '{MD_MULT,  32'd3,          32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{MD_DIVU,  32'd7,          32'd0,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[4] = '{MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[5] = '{MD_DIVU,  32'd100,        32'd7,         1'b0, 32'd2,         32'd14,        10};
    vecs[6] = '{MD_DIV,   32'd7,          32'hFFFF_FFFE, 1'b1, 32'd1,         32'hFFFF_FFFD, 10};
    vecs[7] = '{MD_MULT,  32'h8000_0000,  32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[8] = '{MD_MULTU, 32'h0001_0000,  32'h0001_0000, 1'b1, 32'h0000_0001, 32'h0000_0000, 5};
    vecs[9] = '{MD_DIV,   32'd5,          32'd0,         1'b0, 32'h0000_0001, 32'h0000_0000, 10};

    // Reset with md_use_D high: stall must still be low afterwards.
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.op       = 3'd0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.rd_sel   = 1'b0;
    bus.md_use_D = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset stall", 64'(bus.stall), 64'd0);
    check("reset rd_data", 64'(bus.rd_data), 64'd0);
    reset        = 1'b1;
    bus.md_use_D = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // MTLO then MTHI, one cycle each, no busy window.
    @(negedge clk);
    issue(MD_MTLO, 32'h1234, 32'd0);
    @(negedge clk);
    issue(MD_MTHI, 32'hABCD, 32'd0);
    #1;
    check("mtlo lo", 64'(bus.lo), 64'h1234);
    check("mtlo busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("mthi hi", 64'(bus.hi), 64'hABCD);
    check("mthi lo kept", 64'(bus.lo), 64'h1234);
    bus.rd_sel = 1'b0;
    #1;
    check("rd_sel0", 64'(bus.rd_data), 64'h1234);
    bus.rd_sel = 1'b1;
    #1;
    check("rd_sel1", 64'(bus.rd_data), 64'hABCD);
    bus.rd_sel = 1'b0;

    // A second start inside the MULT busy window is ignored.
    @(negedge clk);
    issue(MD_MULT, 32'd6, 32'd7);
    sb_q.push_back('{hi: 32'd0, lo: 32'd42, cycles: 5});
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      if (n == 2) issue(MD_DIV, 32'd100, 32'd5);
      else        bus.start = 1'b0;
      @(negedge clk);
      #1;
    end
    bus.start = 1'b0;
    e = sb_q.pop_front();
    check("ignore busy_cycles", 64'(n), 64'(e.cycles));
    check("ignore hi", 64'(bus.hi), 64'(e.hi));
    check("ignore lo", 64'(bus.lo), 64'(e.lo));
    @(negedge clk);
    #1;
    check("ignore no_rerun", 64'(bus.busy), 64'd0);

    // Reserved op is a no-op.
    issue(3'd6, 32'hDEAD, 32'hBEEF);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("op6 busy", 64'(bus.busy), 64'd0);
    check("op6 hilo", {bus.hi, bus.lo}, {32'd0, 32'd42});

    // DIVU aborted by reset in cycle 4: nothing ever commits.
    @(negedge clk);
    issue(MD_DIVU, 32'd50, 32'd3);
    bus.md_use_D = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort stall", 64'(bus.stall), 64'd0);
    check("abort hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("abort no_commit", {bus.hi, bus.lo}, 64'd0);
    check("abort idle", 64'(bus.busy), 64'd0);
    bus.md_use_D = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the 5-stage pipeline; it is the XALU source for XALUOut_E.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E stage.
- Holds HI/LO and sequences the busy window with a latency counter.
- Raises a stall request for the hazard logic whenever the instruction in D needs HI/LO while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-low reset; acts on the rising edge of clk when reset==0.
- start  in  1  E-stage instruction is a valid MDU op this cycle.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are reserved and act as no-op.
- src_a  in  32  forwarded rs value (MF_RS_E output).
- src_b  in  32  forwarded rt value (MF_RT_E output).
- rd_sel  in  1  0 = read LO, 1 = read HI; driven by the MFLO/MFHI decode in E.
- md_use_D  in  1  D-stage instruction is any of MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- busy  out  1  an operation is in flight.
- stall  out  1  stall request to the F/D registers and the D/E clear.
- hi  out  32  HI register.
- lo  out  32  LO register.
- rd_data  out  32  equals rd_sel ? hi : lo; combinational, feeds XALUOut_E.

Behaviour:
- Reset (reset==0 at a clock edge): hi=0, lo=0, busy=0, counter=0, pending result=0; stall=0 from the next cycle. A reset arriving mid-operation aborts it; the result is never committed.
- State machine, two states:
  - IDLE: busy=0.
  - RUN: busy=1; a 4-bit counter counts down.
- Transitions out of IDLE:
  - start=1 with op 0..3 in cycle 0: at the edge ending cycle 0, latch the 64-bit result into the pending registers, load the counter with MULT_CYCLES or DIV_CYCLES, and go to RUN.
  - busy is therefore high in cycles 1..N.
- RUN: the counter decrements every edge. At the edge where it goes from 1 to 0, commit the pending result to {hi,lo} and go to IDLE. busy=0 and the new hi/lo are visible in cycle N+1.
- MTHI/MTLO while IDLE: at the edge ending the start cycle, hi (or lo) takes src_a. No busy cycles.
- start while busy=1: ignored; stall makes this case unreachable in the pipeline.
- Arithmetic:
  - MULT: {hi,lo} = signed(src_a) * signed(src_b), 64 bits.
  - MULTU: unsigned 64-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero: still runs DIV_CYCLES, but hi and lo are left unchanged at commit.
  - Signed DIV of 0x80000000 by -1: lo=0x80000000, hi=0.
- stall = md_use_D & (busy | (start & op<=3)). Combinational, with no cycle of lag. Once stall is asserted it holds the D instruction until the cycle in which busy falls.
- rd_data reflects only committed hi/lo; the pending result is never forwarded.

Decomposition:
- Shared package: op encodings (MD_MULT..MD_MTLO), the IDLE/RUN state encoding, and the 4-bit counter width.
- One sub-module, mdu_arith: purely combinational; takes (op, src_a, src_b) and returns a 64-bit result plus a div_by_zero flag.
- mdu_ctrl keeps the FSM, counter, pending registers, HI/LO and stall logic.

Test Plan:
- Reset then idle: reset=0 for 2 cycles -> hi=lo=0, busy=0, stall=0, rd_data=0.
- MULT: src_a=3, src_b=0xFFFFFFFE, start in cycle 0 -> busy=1 in cycles 1..5; hi=0xFFFFFFFF and lo=0xFFFFFFFA in cycle 6.
- DIV then DIVU by zero:
  - DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then DIVU 7/0 -> busy for 10 cycles; hi/lo unchanged.
- Stall:
  - md_use_D=1 held during a MULT -> stall=1 in cycles 0..5 and 0 in cycle 6.
  - md_use_D=0 -> stall=0 throughout.
- MTHI/MTLO and read mux: MTLO src_a=0x1234, then MTHI src_a=0xABCD -> lo=0x1234, hi=0xABCD, each one cycle after its start. rd_sel toggling gives rd_data 0x1234 and 0xABCD.
- Abort and ignore:
  - DIVU started, then reset=0 in cycle 4 -> busy=0, hi=lo=0, no commit.
  - A second start during a MULT's busy window is ignored; the original product commits unaltered.
